// File: rtl/ir_pkg.sv
// Shared definitions for the NEC infrared receive path.
// Contents:
//   ir_state_t    - receiver FSM state encoding (3 bits)
//   CHECK_*       - checksum strictness selectors
//   *_LSB         - bit positions of the four bytes inside a 32-bit NEC frame
//   nec_check_ok  - evaluates the inverted-byte checksum for a given strictness
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEAD_H   = 3'd1,
        LEAD_L   = 3'd2,
        DATA     = 3'd3,
        STOP     = 3'd4,
        REP_STOP = 3'd5
    } ir_state_t;

    localparam int CHECK_NONE = 0;
    localparam int CHECK_CMD  = 1;
    localparam int CHECK_ALL  = 2;

    localparam int NEC_BITS  = 32;
    localparam int ADDR_LSB  = 0;
    localparam int NADDR_LSB = 8;
    localparam int CMD_LSB   = 16;
    localparam int NCMD_LSB  = 24;

    // The command pair is always the stronger guarantee; the address pair is
    // only enforced when the full check is selected (extended-address remotes
    // use a non-inverted second address byte and need CHECK_CMD).
    function automatic logic nec_check_ok(input logic [NEC_BITS-1:0] frame, input int mode);
        logic cmd_ok;
        logic addr_ok;
        cmd_ok  = (frame[NCMD_LSB +: 8] == ~frame[CMD_LSB +: 8]);
        addr_ok = (frame[NADDR_LSB +: 8] == ~frame[ADDR_LSB +: 8]);
        case (mode)
            CHECK_NONE: return 1'b1;
            CHECK_CMD:  return cmd_ok;
            CHECK_ALL:  return cmd_ok && addr_ok;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Counter-based enable generator: asserts tick for one clk out of every DIV.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-clk enable pulse, period DIV clocks
module ir_tick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // Free-running modulo-DIV counter; tick is registered so downstream logic
    // sees a clean single-cycle enable aligned to the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared receiver. Samples the demodulator output on a 1 us tick,
// measures mark/space durations and decodes lead, 32 data bits and repeat
// codes, validating the inverted-byte checksum.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   i_ir_rxb - raw demodulator output (asynchronous)
//   o_data   - last valid frame {~cmd, cmd, ~addr, addr}
//   o_valid  - one-clk pulse, o_data updated on the same edge
//   o_repeat - one-clk pulse on an accepted repeat code
//   o_err    - one-clk pulse on a malformed frame or timeout
//   o_busy   - high whenever a frame is in progress
module ir_nec_rx
    import ir_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int RX_INV     = 1,
    parameter int CNT_W      = 17,
    parameter int LEAD_H_MIN = 8500,
    parameter int LEAD_L_MIN = 4000,
    parameter int REP_L_MIN  = 1800,
    parameter int BIT1_L_MIN = 1000,
    parameter int MARK_MAX   = 1000,
    parameter int TIMEOUT    = 12000,
    parameter int CHECK_MODE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ir_rxb,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_err,
    output logic        o_busy
);

    localparam int               DIV          = CLK_HZ / 1000000;
    localparam logic             IDLE_LVL     = (RX_INV != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] LEAD_H_MIN_C = CNT_W'(LEAD_H_MIN);
    localparam logic [CNT_W-1:0] LEAD_L_MIN_C = CNT_W'(LEAD_L_MIN);
    localparam logic [CNT_W-1:0] REP_L_MIN_C  = CNT_W'(REP_L_MIN);
    localparam logic [CNT_W-1:0] BIT1_L_MIN_C = CNT_W'(BIT1_L_MIN);
    localparam logic [CNT_W-1:0] MARK_MAX_C   = CNT_W'(MARK_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);

    logic                rx_meta;
    logic                rx_sync;
    logic                mark;
    logic                prev_mark;
    logic                tick;
    logic                rise;
    logic                fall;
    logic [CNT_W-1:0]    cnt;

    ir_state_t           state;
    ir_state_t           state_nxt;
    logic [5:0]          bitcnt;
    logic [5:0]          bitcnt_nxt;
    logic [NEC_BITS-1:0] shift;
    logic [NEC_BITS-1:0] shift_nxt;
    logic [NEC_BITS-1:0] data_nxt;
    logic                rep_ok;
    logic                rep_ok_nxt;
    logic                valid_nxt;
    logic                repeat_nxt;
    logic                err_nxt;

    ir_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchroniser. Flops reset to the idle line level so that
    // leaving reset never looks like the start of a mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= IDLE_LVL;
            rx_sync <= IDLE_LVL;
        end else begin
            rx_meta <= i_ir_rxb;
            rx_sync <= rx_meta;
        end
    end

    assign mark = rx_sync ^ IDLE_LVL;
    assign rise = tick &  mark & ~prev_mark;
    assign fall = tick & ~mark &  prev_mark;

    // Level history and duration counter only advance on tick, so every
    // duration below is in microseconds. The counter saturates rather than
    // wrapping so a stuck line can never alias to a legal duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mark <= 1'b0;
            cnt       <= '0;
        end else if (tick) begin
            prev_mark <= mark;
            if (rise || fall) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state and strobe logic. Everything is qualified by tick; the
    // timeout test sits ahead of the per-state edge handling so it wins over
    // an edge seen on the same tick.
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shift_nxt  = shift;
        data_nxt   = o_data;
        rep_ok_nxt = rep_ok;
        valid_nxt  = 1'b0;
        repeat_nxt = 1'b0;
        err_nxt    = 1'b0;
        if (tick) begin
            if ((state != IDLE) && (cnt >= TIMEOUT_C)) begin
                err_nxt    = 1'b1;
                rep_ok_nxt = 1'b0;
                state_nxt  = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) state_nxt = LEAD_H;
                    end
                    LEAD_H: begin
                        if (fall) state_nxt = (cnt >= LEAD_H_MIN_C) ? LEAD_L : IDLE;
                    end
                    LEAD_L: begin
                        if (rise) begin
                            if (cnt >= LEAD_L_MIN_C) begin
                                state_nxt  = DATA;
                                bitcnt_nxt = '0;
                            end else if (cnt >= REP_L_MIN_C) begin
                                state_nxt = REP_STOP;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                    end
                    DATA: begin
                        if (fall && (cnt > MARK_MAX_C)) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else if (rise) begin
                            shift_nxt[bitcnt[4:0]] = (cnt >= BIT1_L_MIN_C);
                            bitcnt_nxt             = bitcnt + 6'd1;
                            if (bitcnt == 6'd31) state_nxt = STOP;
                        end
                    end
                    STOP: begin
                        if (fall) begin
                            if (nec_check_ok(shift, CHECK_MODE)) begin
                                data_nxt   = shift;
                                valid_nxt  = 1'b1;
                                rep_ok_nxt = 1'b1;
                            end else begin
                                err_nxt    = 1'b1;
                                rep_ok_nxt = 1'b0;
                            end
                            state_nxt = IDLE;
                        end
                    end
                    REP_STOP: begin
                        if (fall) begin
                            repeat_nxt = rep_ok;
                            state_nxt  = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // State, shift register and registered outputs. Reset clears any partial
    // frame and forgets the last valid frame for repeat purposes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shift    <= '0;
            rep_ok   <= 1'b0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_repeat <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            bitcnt   <= bitcnt_nxt;
            shift    <= shift_nxt;
            rep_ok   <= rep_ok_nxt;
            o_data   <= data_nxt;
            o_valid  <= valid_nxt;
            o_repeat <= repeat_nxt;
            o_err    <= err_nxt;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_ir_nec_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for ir_nec_rx. Two instances share one line: an
// active-low receiver at 2 MHz and an active-high receiver at 4 MHz. NEC
// timings are scaled down (about 1/50) to keep the run short; thresholds are
// overridden to match.
module tb_ir_nec_rx;

    localparam int T_LH_MIN = 170;
    localparam int T_LL_MIN = 80;
    localparam int T_RL_MIN = 36;
    localparam int T_B1_MIN = 22;
    localparam int T_MMAX   = 22;
    localparam int T_TO     = 240;
    localparam int GAP      = 100;

    localparam int EV_VALID  = 0;
    localparam int EV_REPEAT = 1;
    localparam int EV_ERR    = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic        clk      = 1'b0;
    logic        clk2     = 1'b0;
    logic        rst_n    = 1'b0;
    logic        mark_lvl = 1'b0;
    logic        ir_lo;
    logic        ir_hi;
    logic [31:0] o_data1;
    logic        o_valid1;
    logic        o_repeat1;
    logic        o_err1;
    logic        o_busy1;
    logic [31:0] o_data2;
    logic        o_valid2;
    logic        o_repeat2;
    logic        o_err2;
    logic        o_busy2;

    int          checks   = 0;
    int          failures = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] model_data   = '0;
    logic        model_rep_ok = 1'b0;
    realtime     t_last       = 0.0;
    logic [2:0]  prev_s1      = '0;
    logic [2:0]  prev_s2      = '0;

    assign ir_lo = ~mark_lvl;
    assign ir_hi = mark_lvl;

    always #250 clk  = ~clk;
    always #125 clk2 = ~clk2;

    ir_nec_rx #(
        .CLK_HZ(2000000), .RX_INV(1), .CNT_W(17),
        .LEAD_H_MIN(T_LH_MIN), .LEAD_L_MIN(T_LL_MIN), .REP_L_MIN(T_RL_MIN),
        .BIT1_L_MIN(T_B1_MIN), .MARK_MAX(T_MMAX), .TIMEOUT(T_TO), .CHECK_MODE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_ir_rxb(ir_lo), .o_data(o_data1),
        .o_valid(o_valid1), .o_repeat(o_repeat1), .o_err(o_err1), .o_busy(o_busy1)
    );

    ir_nec_rx #(
        .CLK_HZ(4000000), .RX_INV(0), .CNT_W(17),
        .LEAD_H_MIN(T_LH_MIN), .LEAD_L_MIN(T_LL_MIN), .REP_L_MIN(T_RL_MIN),
        .BIT1_L_MIN(T_B1_MIN), .MARK_MAX(T_MMAX), .TIMEOUT(T_TO), .CHECK_MODE(2)
    ) dut2 (
        .clk(clk2), .rst_n(rst_n), .i_ir_rxb(ir_hi), .o_data(o_data2),
        .o_valid(o_valid2), .o_repeat(o_repeat2), .o_err(o_err2), .o_busy(o_busy2)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic compareEvent(input string tag, input logic [2:0] s, input logic [31:0] d, input exp_t e);
        checkOutput({tag, " strobe kind"}, 64'(s), 64'(3'b001) << e.kind);
        checkOutput({tag, " o_data"}, 64'(d), 64'(e.data));
    endtask

    function automatic void pushExp(input int kind, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        q1.push_back(e);
        q2.push_back(e);
    endfunction

    // Frame-level reference: a complete frame is valid only when both byte
    // pairs are bitwise complements; a valid frame arms repeats, a rejected
    // or abandoned frame disarms them.
    function automatic logic frameOk(input logic [31:0] w);
        logic [7:0] a, na, c, nc;
        a  = w[7:0];
        na = w[15:8];
        c  = w[23:16];
        nc = w[31:24];
        return ((a ^ na) == 8'hFF) && ((c ^ nc) == 8'hFF);
    endfunction

    task automatic drive(input logic m, input int us);
        mark_lvl = m;
        #(us * 1000);
    endtask

    // Monitor for the active-low instance: each strobe pops one expectation.
    always @(negedge clk) begin : mon1
        exp_t       e;
        logic [2:0] s;
        s = {o_err1, o_repeat1, o_valid1};
        if (s != 3'b000) begin
            checkOutput("dut1 strobe width", 64'(prev_s1), 64'd0);
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected strobe", 64'(s), 64'd0);
            end else begin
                e = q1.pop_front();
                compareEvent("dut1", s, o_data1, e);
            end
        end
        prev_s1 = s;
    end

    // Monitor for the active-high instance.
    always @(negedge clk2) begin : mon2
        exp_t       e;
        logic [2:0] s;
        s = {o_err2, o_repeat2, o_valid2};
        if (s != 3'b000) begin
            checkOutput("dut2 strobe width", 64'(prev_s2), 64'd0);
            if (q2.size() == 0) begin
                checkOutput("dut2 unexpected strobe", 64'(s), 64'd0);
            end else begin
                e = q2.pop_front();
                compareEvent("dut2", s, o_data2, e);
            end
        end
        prev_s2 = s;
    end

    // kind: 0 full frame, 1 repeat code, 2 short lead, 3 frame abandoned
    // after nbits bits. rst_bit >= 0 pulses reset at the start of that bit.
    task automatic applyStimulus(input int kind, input logic [31:0] word, input int nbits, input int rst_bit);
        if (rst_bit < 0) begin
            case (kind)
                0: begin
                    if (frameOk(word)) begin
                        model_data   = word;
                        model_rep_ok = 1'b1;
                        pushExp(EV_VALID, word);
                    end else begin
                        model_rep_ok = 1'b0;
                        pushExp(EV_ERR, model_data);
                    end
                end
                1: if (model_rep_ok) pushExp(EV_REPEAT, model_data);
                3: begin
                    model_rep_ok = 1'b0;
                    pushExp(EV_ERR, model_data);
                end
                default: ;
            endcase
        end
        if (kind == 2) begin
            drive(1'b1, 140);
            drive(1'b0, GAP);
            return;
        end
        drive(1'b1, int'($urandom_range(190, 175)));
        if (kind == 1) begin
            drive(1'b0, int'($urandom_range(50, 40)));
            drive(1'b1, int'($urandom_range(13, 9)));
            drive(1'b0, GAP);
            return;
        end
        drive(1'b0, int'($urandom_range(95, 85)));
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                checkOutput("dut1 busy mid-frame", 64'(o_busy1), 64'd1);
                checkOutput("dut2 busy mid-frame", 64'(o_busy2), 64'd1);
                rst_n = 1'b0;
                #1;
                checkOutput("dut1 outputs in reset", 64'({o_data1, o_valid1, o_repeat1, o_err1, o_busy1}), 64'd0);
                checkOutput("dut2 outputs in reset", 64'({o_data2, o_valid2, o_repeat2, o_err2, o_busy2}), 64'd0);
                model_data   = '0;
                model_rep_ok = 1'b0;
                mark_lvl     = 1'b0;
                #2000;
                rst_n = 1'b1;
                drive(1'b0, GAP);
                return;
            end
            drive(1'b1, int'($urandom_range(13, 9)));
            if (kind == 3 && i == nbits - 1) begin
                mark_lvl = 1'b0;
                t_last   = $realtime;
                return;
            end
            drive(1'b0, word[i] ? int'($urandom_range(38, 30)) : int'($urandom_range(13, 9)));
        end
        drive(1'b1, int'($urandom_range(13, 9)));
        drive(1'b0, GAP);
    endtask

    // Hang guard.
    initial begin
        #50_000_000;
        failures++;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a short randomized run.
    initial begin
        logic        got;
        real         dt;
        logic [31:0] word;
        logic [7:0]  a, c;
        int          r;
        int          sel;

        got = 1'b0;
        dt  = 0.0;
        #1000;
        checkOutput("dut1 reset outputs", 64'({o_data1, o_valid1, o_repeat1, o_err1, o_busy1}), 64'd0);
        checkOutput("dut2 reset outputs", 64'({o_data2, o_valid2, o_repeat2, o_err2, o_busy2}), 64'd0);
        #1000;
        rst_n = 1'b1;
        drive(1'b0, 50);

        $display("[TB] repeat with no prior frame");
        applyStimulus(1, 32'h0, 0, -1);

        $display("[TB] valid frame addr 00 cmd 45");
        applyStimulus(0, 32'hBA45FF00, 32, -1);
        checkOutput("dut1 o_data after frame", 64'(o_data1), 64'hBA45FF00);
        checkOutput("dut2 o_data after frame", 64'(o_data2), 64'hBA45FF00);

        $display("[TB] repeat after valid frame");
        applyStimulus(1, 32'h0, 0, -1);
        checkOutput("dut1 o_data after repeat", 64'(o_data1), 64'hBA45FF00);

        $display("[TB] bad ~cmd byte, then repeat");
        applyStimulus(0, 32'hBB45FF00, 32, -1);
        applyStimulus(1, 32'h0, 0, -1);
        checkOutput("dut1 o_data after bad frame", 64'(o_data1), 64'hBA45FF00);
        checkOutput("dut2 o_data after bad frame", 64'(o_data2), 64'hBA45FF00);

        $display("[TB] short lead mark");
        applyStimulus(2, 32'h0, 0, -1);
        checkOutput("dut1 idle after short lead", 64'(o_busy1), 64'd0);

        $display("[TB] frame abandoned after 20 bits");
        applyStimulus(3, 32'hBA45FF00, 20, -1);
        for (int k = 0; k < (T_TO + 60) * 2 && !got; k++) begin
            @(negedge clk);
            if (o_err1) begin
                got = 1'b1;
                dt  = ($realtime - t_last) / 1000.0;
            end
        end
        checkOutput("dut1 timeout err seen", 64'(got), 64'd1);
        checkOutput("dut1 busy at timeout", 64'(o_busy1), 64'd0);
        if (got) checkRange("dut1 timeout delay us", int'(dt), T_TO - 2, T_TO + 6);
        drive(1'b0, GAP);

        $display("[TB] reset mid-frame, then clean frame");
        applyStimulus(0, 32'hE31C7F80, 32, 12);
        applyStimulus(0, 32'hBA45FF00, 32, -1);
        checkOutput("dut1 o_data after reset recovery", 64'(o_data1), 64'hBA45FF00);

        $display("[TB] randomized frames");
        for (int n = 0; n < 6; n++) begin
            a    = 8'($urandom);
            c    = 8'($urandom);
            r    = int'($urandom_range(9, 0));
            sel  = int'($urandom_range(3, 0));
            word = {~c, c, ~a, a};
            if (r >= 8) word = word ^ ({24'd0, 8'($urandom_range(255, 1))} << (8 * sel));
            applyStimulus((r >= 6 && r < 8) ? 1 : 0, word, 32, -1);
        end

        drive(1'b0, 300);
        checkOutput("dut1 pending expectations", 64'(q1.size()), 64'd0);
        checkOutput("dut2 pending expectations", 64'(q2.size()), 64'd0);
        checkOutput("dut1 final o_data", 64'(o_data1), 64'(model_data));
        checkOutput("dut2 final o_data", 64'(o_data2), 64'(model_data));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_nec_rx.md
Name: ir_nec_rx

Overview:
Parametrised NEC infrared receiver and the successor to the fixed 1 µs / 32-bit IR receive logic. It samples the raw demodulator output in a single clock domain using a tick enable, not a derived clock. It decodes the lead code, 32 data bits and repeat codes, and validates the inverted-byte checksum. It delivers the frame to downstream display/control logic with a one-cycle valid strobe, plus separate repeat and error strobes.

Parameters:
CLK_HZ, 50000000, system clock frequency; tick divider DIV = CLK_HZ/1000000 (1 µs tick); DIV >= 2.
RX_INV, 1, 1 = input is active-low (mark = 0); 0 = active-high.
CNT_W, 17, width of the µs duration counter; saturates, never wraps.
LEAD_H_MIN, 8500, minimum lead mark, µs.
LEAD_L_MIN, 4000, minimum lead space for a data frame, µs.
REP_L_MIN, 1800, minimum lead space for a repeat code, µs; must be < LEAD_L_MIN.
BIT1_L_MIN, 1000, data space >= this decodes as 1, otherwise 0, µs.
MARK_MAX, 1000, maximum data/stop mark length, µs.
TIMEOUT, 12000, maximum length of any single level outside IDLE, µs.
CHECK_MODE, 2, 0 = no check; 1 = command pair only; 2 = address and command pairs.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_ir_rxb  in  1  raw IR demodulator output, asynchronous
o_data  out  32  last valid frame: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
o_valid  out  1  one-clk pulse; o_data updated on the same edge
o_repeat  out  1  one-clk pulse on an accepted repeat code
o_err  out  1  one-clk pulse on a malformed frame
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: single clock clk; reset rst_n asynchronous and active-low.
- Reset: all outputs 0, state IDLE, counters 0, rep_ok 0. Reset mid-frame discards the partial frame and emits no strobes.
- Input path: 2-flop synchroniser on clk, then polarity fix by RX_INV, giving mark = 1. The level is sampled on tick (1 clk every DIV clks) into a previous-level register.
- Edge detection: rise = mark start, fall = space start; both evaluated on tick only.
- Duration counter: cleared on each edge, +1 per tick otherwise, saturates at 2^CNT_W-1.
- IDLE: on rise -> LEAD_H.
- LEAD_H: on fall with cnt >= LEAD_H_MIN -> LEAD_L. On fall with cnt < LEAD_H_MIN -> IDLE silently (noise, no err).
- LEAD_L, on rise:
  - cnt >= LEAD_L_MIN -> DATA, bitcnt = 0.
  - REP_L_MIN <= cnt < LEAD_L_MIN -> REP_STOP.
  - cnt < REP_L_MIN -> o_err, IDLE.
- DATA, on fall: cnt > MARK_MAX -> o_err, IDLE.
- DATA, on rise (end of a space): shift bit (cnt >= BIT1_L_MIN) into shift[bitcnt], LSB first; bitcnt += 1. When bitcnt reaches 32 -> STOP.
- STOP, on fall (end of stop mark):
  - Checksum: mode 1 requires [31:24] == ~[23:16]; mode 2 additionally requires [15:8] == ~[7:0].
  - Pass: o_data <= shift, o_valid = 1, rep_ok <= 1.
  - Fail: o_err, rep_ok <= 0, o_data unchanged.
  - Either way -> IDLE.
- REP_STOP, on fall: if rep_ok, o_repeat = 1, otherwise no strobe; -> IDLE.
- Timeout: in any non-IDLE state, cnt >= TIMEOUT -> o_err, IDLE, rep_ok <= 0. This takes priority over a simultaneous edge.
- Strobe latency: strobes assert on the clk edge following the tick that detects the terminating edge. End-to-end latency from the pin edge is 2 clk + up to DIV clk + 1 clk.
- Strobe exclusivity: strobes are mutually exclusive and never longer than 1 clk.
- o_data between frames: holds its value until the next valid frame; repeats do not alter it.

Decomposition:
- Shared package ir_pkg:
  - state encoding constants IDLE, LEAD_H, LEAD_L, DATA, STOP, REP_STOP (3 bits);
  - CHECK_MODE constants;
  - NEC byte-field index constants.
- One natural sub-module: ir_tick_gen (counter-based 1-clk enable generator, parameter DIV), reusable by other timing blocks in the codebase.
- Synchroniser, edge detect and FSM stay in ir_nec_rx.

Test Plan:
- Valid frame, addr 0x00, cmd 0x45 (9 ms/4.5 ms lead, 560 µs marks, 560/1690 µs spaces) -> o_data = 32'hBA45FF00, exactly one o_valid pulse, o_err = 0.
- Same frame, then repeat code (9 ms/2.25 ms/560 µs) -> one o_repeat, o_data still 32'hBA45FF00. Repeat with no prior valid frame after reset -> no strobe.
- Frame with cmd 0x45, ~cmd byte 0xBB, CHECK_MODE = 2 -> o_err pulse, o_data unchanged, following repeat code ignored.
- Frame stopped after 20 bits, line idle -> o_err exactly TIMEOUT µs after the last edge, o_busy falls, no o_valid.
- 7 ms lead mark -> return to IDLE, no strobe. rst_n pulsed low mid-frame (bit 12) -> all outputs 0 immediately; next clean frame decodes correctly.
- CLK_HZ = 25000000 with RX_INV = 0 and an active-high stimulus of the first scenario -> identical o_data = 32'hBA45FF00.
